// File: rtl/indication_portal_scheduler_pkg.sv
// Shared types and constants for the indication portal scheduler.
package indication_sched_pkg;

   // Scheduler FSM: arbitrate in IDLE, move one whole message in XFER.
   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam int IND_DATA_W     = 32;
   localparam int INTR_CHANNEL_W = 32;

   // Width of a source index; never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/indication_portal_scheduler_picker.sv
// Round-robin picker: first requesting source above last_grant, wrapping.
module rr_priority_picker #(
   parameter int NUM_SRC = 2,
   parameter int GW      = 1
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [GW-1:0]      last_grant,
   output logic [GW-1:0]      grant,
   output logic               any_req
);

   // Walk offsets 1..NUM_SRC from last_grant so the previous winner is checked last.
   always_comb begin
      int idx;
      idx     = 0;
      grant   = '0;
      any_req = 1'b0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         idx = (int'(last_grant) + i) % NUM_SRC;
         for (int j = 0; j < NUM_SRC; j++) begin
            if (!any_req && (idx == j) && req[j]) begin
               any_req = 1'b1;
               grant   = GW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/indication_portal_scheduler.sv
// Shares the host indication read port among NUM_SRC message sources,
// granting round-robin and holding each grant for one complete message.
//
// Host handshake: a word moves when EN_indication && RDY_indication are both
// high in the same cycle; that cycle pulses src_deq for the granted source.
// RDY_indication never depends on EN_indication.
module indication_portal_scheduler
   import indication_sched_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int DATA_W  = IND_DATA_W,
   parameter int LEN_W   = 8
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic [NUM_SRC-1:0]          src_not_empty,
   input  logic [NUM_SRC*DATA_W-1:0]   src_first,
   input  logic [NUM_SRC*LEN_W-1:0]    src_msg_words,
   output logic [NUM_SRC-1:0]          src_deq,
   input  logic                        intr_enable,
   input  logic                        EN_indication,
   output logic [DATA_W-1:0]           indicationData,
   output logic                        RDY_indication,
   output logic                        indIntrStatus,
   output logic [INTR_CHANNEL_W-1:0]   indIntrChannel,
   output logic                        err_underflow,
   output logic                        dbg_state
);

   localparam int GW = idx_w(NUM_SRC);

   state_t            state;
   logic [GW-1:0]     grant;
   logic [GW-1:0]     last_grant;
   logic [GW-1:0]     pick;
   logic              any_req;
   logic [LEN_W-1:0]  count;
   logic [LEN_W-1:0]  pick_len;
   logic              gnt_ne;
   logic [DATA_W-1:0] gnt_data;
   logic              rdy;
   logic              rd;

   rr_priority_picker #(
      .NUM_SRC (NUM_SRC),
      .GW      (GW)
   ) u_picker (
      .req        (src_not_empty),
      .last_grant (last_grant),
      .grant      (pick),
      .any_req    (any_req)
   );

   // Select the granted source's status/data and the candidate's message length.
   always_comb begin
      gnt_ne   = 1'b0;
      gnt_data = '0;
      pick_len = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == GW'(i)) begin
            gnt_ne   = src_not_empty[i];
            gnt_data = src_first[i*DATA_W +: DATA_W];
         end
         if (pick == GW'(i)) begin
            pick_len = src_msg_words[i*LEN_W +: LEN_W];
         end
      end
   end

   // Host-side handshake, dequeue strobe and interrupt outputs.
   always_comb begin
      rdy            = (state == XFER) && gnt_ne;
      rd             = rdy && EN_indication;
      src_deq        = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_deq[i] = rd && (grant == GW'(i));
      end
      indicationData = (state == XFER) ? gnt_data : '0;
      indIntrStatus  = (state == XFER) && intr_enable;
      indIntrChannel = indIntrStatus ? (INTR_CHANNEL_W'(grant) + INTR_CHANNEL_W'(1)) : '0;
   end

   assign RDY_indication = rdy;
   assign dbg_state      = state;

   // Scheduler FSM: grant and load length in IDLE, count reads down in XFER.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         grant         <= '0;
         last_grant    <= GW'(NUM_SRC - 1);
         count         <= '0;
         err_underflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant <= pick;
                  count <= (pick_len == '0) ? LEN_W'(1) : pick_len;
                  state <= XFER;
               end
            end
            XFER: begin
               if (rd) begin
                  count <= count - LEN_W'(1);
                  if (count == LEN_W'(1)) begin
                     last_grant <= grant;
                     state      <= IDLE;
                  end
               end else if (EN_indication) begin
                  err_underflow <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/indication_portal_scheduler.md
Name: indication_portal_scheduler

Overview:
- Shares the single host indication read port among NUM_SRC indication-output FIFOs.
- Each source delivers multi-word messages. The scheduler grants sources in round-robin order and holds a grant for one whole message.
- Drives the host data/ready/deq handshake plus the interrupt status/channel pair.
- Sits between the indication-output portals and the top-level indication port.

Parameters:
- NUM_SRC, 2, number of indication sources; legal range 2..8.
- DATA_W, 32, indication word width.
- LEN_W, 8, width of the per-source message-length field, in words.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- src_not_empty  input  NUM_SRC  bit i high means source i has a head word available.
- src_first  input  NUM_SRC*DATA_W  head word of each source; source i occupies bits [i*DATA_W +: DATA_W].
- src_msg_words  input  NUM_SRC*LEN_W  word count of the head message of each source; sampled only at grant.
- src_deq  output  NUM_SRC  one-hot dequeue strobe to the granted source.
- intr_enable  input  1  gates the interrupt status.
- EN_indication  input  1  host read strobe.
- indicationData  output  DATA_W  head word of the granted source.
- RDY_indication  output  1  host may read this cycle.
- indIntrStatus  output  1  a message is pending on the host port.
- indIntrChannel  output  32  granted source index + 1; 0 when no interrupt.
- err_underflow  output  1  sticky flag: a read was attempted without ready.

Behaviour:
- Reset values while RST_N is low:
  - state=IDLE, grant=0, last_grant=NUM_SRC-1 (so source 0 wins first), count=0, err_underflow=0.
  - All outputs low/zero.
- States: IDLE, XFER.
- IDLE:
  - If any src_not_empty bit is set, pick the first set bit searching upward from last_grant+1, modulo NUM_SRC.
  - Register that source as grant.
  - Load count = src_msg_words[grant]; a value of 0 is treated as 1.
  - Go to XFER on the next cycle.
  - Host outputs are not valid in IDLE: RDY_indication=0, indicationData=0.
- XFER, combinational outputs:
  - indicationData = src_first[grant].
  - RDY_indication = src_not_empty[grant].
- XFER, successful read (EN_indication && RDY_indication):
  - src_deq[grant]=1 in the same cycle (combinational; no other src_deq bit is ever high).
  - count decrements.
  - If count==1: latch last_grant=grant and return to IDLE.
- XFER, read without ready (EN_indication while RDY_indication=0):
  - No dequeue, no count change, err_underflow set to 1 and held until reset.
- XFER, source runs dry mid-message: remain in XFER with RDY_indication=0. No timeout; the grant is never preempted.
- EN_indication in IDLE: ignored and does not set err_underflow.
- Latency:
  - Data is visible to the host 1 cycle after src_not_empty rises in IDLE.
  - There is a 1-idle-cycle gap between consecutive messages; this is the arbitration cycle.
- Fairness: the source that just completed a message has the lowest priority in the next arbitration.
- Interrupt:
  - indIntrStatus = (state==XFER) && intr_enable.
  - indIntrChannel = indIntrStatus ? zero-extended(grant)+1 : 0.
- Input stability: changes to src_msg_words during XFER have no effect.
- Reset asserted mid-message: the partial message is abandoned and no src_deq fires. Afterward the block arbitrates from source 0.

Decomposition:
- Shared package (indication_sched_pkg):
  - state enum {IDLE, XFER}.
  - IND_DATA_W=32.
  - INTR_CHANNEL_W=32.
- Sub-module rr_priority_picker:
  - Purely combinational.
  - Inputs: NUM_SRC request vector, last_grant.
  - Outputs: grant index, any_req.

Test Plan:
- Single message: src1 not_empty, msg_words=3, host strobes EN every cycle → indIntrChannel=2; exactly 3 src_deq[1] pulses; IDLE after the 3rd read; indIntrChannel=0 the next cycle.
- Contention fairness: both sources continuously non-empty, msg_words=2 each, out of reset → grant order 0,1,0,1; 1-cycle gap between messages; no src_deq on a non-granted source.
- Source stall: grant src0, msg_words=4, src0 not_empty drops after 2 reads for 5 cycles → RDY_indication=0, grant held, data resumes, 2 further deqs, then IDLE.
- Underflow: EN_indication during a stall → err_underflow=1 sticky, count unchanged; EN_indication in IDLE → flag not set.
- Zero length and interrupt gating: msg_words=0 → single read completes the message; intr_enable=0 → indIntrStatus=0 and indIntrChannel=0 while data still transfers.
- Reset mid-XFER: RST_N pulsed low after 1 of 3 reads → outputs zero immediately (asynchronous); afterward src0 granted first when both sources are non-empty.
